// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: types and defaults shared by the UART receive controller.
//   rx_state_t      receive FSM state encoding (ST_PARITY only with UART_RX_PARITY_EN)
//   DATA_BITS_DEF   default data bits per frame
//   SYNC_STAGES_DEF default rx synchronizer depth
//   cnt_width()     bit-counter width able to hold 0..data_bits
package uart_rx_pkg;

  localparam int DATA_BITS_DEF   = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic int cnt_width(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_sync.sv
// rx_sync: multi-flop synchronizer for the asynchronous rx pin.
// Resets to 1 so a reset never looks like a start bit.
//   clk    system clock
//   rstn   asynchronous active-low reset
//   d_i    asynchronous input
//   q_o    synchronized output, STAGES clocks behind d_i
module rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '1;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller. Detects start bits, runs the external
// mid-bit baud generator through baud_ena, samples rx on each baud_tick and
// hands finished bytes to the consumer through a valid/ready holding register.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
//   clk         system clock
//   rstn        asynchronous active-low reset
//   rx          raw serial input, idle high
//   baud_tick   mid-bit pulse from the baud generator
//   baud_ena    run enable to the baud generator
//   dout        received byte
//   dout_valid  dout holds an unconsumed byte
//   dout_ready  consumer accepts dout
//   frame_err   pulse: stop bit sampled low
//   parity_err  pulse: parity mismatch (0 without UART_RX_PARITY_EN)
//   overrun     pulse: completed byte dropped, holding register full
//   busy        FSM not in IDLE
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | line idle, waiting for rx_s low
// ST_START  | confirming the start bit at its mid-point
// ST_DATA   | shifting in DATA_BITS data bits, LSB first
// ST_PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// ST_STOP   | sampling the stop bit, delivering or flagging
// ST_BREAK  | stop bit was low; wait for the line to go high
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic                 baud_ena,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = cnt_width(DATA_BITS);

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 baud_ena_q, baud_ena_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_s, tick, deliver;

  rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  // Ticks arriving while the generator is held in reload are stale.
  assign tick = baud_tick & baud_ena_q;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
`else
  // Parity sense has no effect when parity support is not built.
  localparam bit unused_parity_odd = PARITY_ODD;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    deliver      = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_DATA;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          par_bad_d = rx_s ^ (^shift_q) ^ PARITY_ODD;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
            deliver      = !par_bad_q;
`else
            deliver      = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    baud_ena_d = (state_d != ST_IDLE) && (state_d != ST_BREAK);

    // A consume and a new load in the same cycle keep dout_valid high.
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
    if (deliver) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = shift_q;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      baud_ena_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      baud_ena_q   <= baud_ena_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign baud_ena   = baud_ena_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl paired with a
// mid-bit baud generator (16 clocks per bit). Expected bytes go into exp_q
// when a frame is sent; a monitor records each newly loaded dout into obs_q.
module tb_uart_rx_ctrl;

  localparam int DATA_BITS  = 8;
  localparam int SYNC       = 2;
  localparam bit PARITY_ODD = 1'b0;
  localparam int BAUDRATE   = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NTICKS = DATA_BITS + 3;
`else
  localparam int NTICKS = DATA_BITS + 2;
`endif

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 rx = 1'b1;
  logic                 baud_tick;
  logic                 baud_ena;
  logic [DATA_BITS-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready = 1'b0;
  logic                 frame_err, parity_err, overrun, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DATA_BITS   (DATA_BITS),
    .SYNC_STAGES (SYNC),
    .PARITY_ODD  (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .baud_tick  (baud_tick),
    .baud_ena   (baud_ena),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Baud generator: held at half a bit while disabled so the first tick
  // lands near the middle of the start bit.
  int bcnt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                bcnt <= BAUDRATE/2 - 1;
    else if (!baud_ena)       bcnt <= BAUDRATE/2 - 1;
    else if (bcnt == 0)       bcnt <= BAUDRATE - 1;
    else                      bcnt <= bcnt - 1;
  end
  assign baud_tick = baud_ena && (bcnt == 0);

  logic [DATA_BITS-1:0] exp_q[$];
  logic [DATA_BITS-1:0] obs_q[$];
  int n_frame_err = 0, n_par_err = 0, n_overrun = 0, n_valid_cyc = 0, n_ticks = 0;
  bit took = 1'b0;
  bit v_prev = 1'b0;

  always @(posedge clk) took = dout_valid && dout_ready;

  always @(negedge clk) begin
    if (dout_valid && (!v_prev || took)) obs_q.push_back(dout);
    v_prev = dout_valid;
    if (frame_err)  n_frame_err++;
    if (parity_err) n_par_err++;
    if (overrun)    n_overrun++;
    if (dout_valid) n_valid_cyc++;
    if (baud_tick)  n_ticks++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clks(BAUDRATE);
  endtask

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_bit,
                            input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit === 1'bx) rx = 1'b1;
`endif
    drive_bit(stop_bit);
  endtask

  task automatic wait_obs(output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 64) begin
      wait_clks(1);
      n++;
    end
    ok = (obs_q.size() != 0);
  endtask

  task automatic test_reset();
    logic [DATA_BITS+5:0] v;
    rstn = 1'b0;
    rx = 1'b0;
    wait_clks(4);
    v = {baud_ena, dout, dout_valid, frame_err, parity_err, overrun, busy};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h required 0", v);
    end
    rx = 1'b1;
    wait_clks(2);
    rstn = 1'b1;
    wait_clks(10);
    v = {baud_ena, dout, dout_valid, frame_err, parity_err, overrun, busy};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL reset_idle: outputs=%h required 0", v);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [DATA_BITS-1:0] got, e;
    int fe0 = n_frame_err, pe0 = n_par_err, ov0 = n_overrun;
    dout_ready = 1'b1;
    n_valid_cyc = 0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, par_of(8'hA5));
    wait_clks(4);
    wait_obs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_byte: no byte delivered, required a5");
    end else begin
      got = obs_q.pop_front();
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL basic_byte: dout=%h required %h", got, e);
      end
    end
    checks++;
    if (n_valid_cyc != 1) begin
      errors++;
      $display("FAIL basic_valid_len: dout_valid cycles=%0d required 1", n_valid_cyc);
    end
    checks++;
    if ((n_frame_err - fe0) + (n_par_err - pe0) + (n_overrun - ov0) != 0) begin
      errors++;
      $display("FAIL basic_no_err: error pulses=%0d required 0",
               (n_frame_err - fe0) + (n_par_err - pe0) + (n_overrun - ov0));
    end
    checks++;
    if ({baud_ena, busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_idle: baud_ena,busy=%b required 00", {baud_ena, busy});
    end
  endtask

  task automatic test_false_start();
    bit ok;
    logic [DATA_BITS-1:0] got, e;
    int t0 = n_ticks, v0 = n_valid_cyc;
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    wait_clks(40);
    checks++;
    if (n_ticks - t0 != 1) begin
      errors++;
      $display("FAIL false_start_ticks: ticks=%0d required 1", n_ticks - t0);
    end
    checks++;
    if ({baud_ena, busy, dout_valid} !== 3'b000 || n_valid_cyc != v0) begin
      errors++;
      $display("FAIL false_start_idle: baud_ena,busy,dout_valid=%b valid_cycles=%0d required 000 0",
               {baud_ena, busy, dout_valid}, n_valid_cyc - v0);
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, par_of(8'h3C));
    wait_obs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL false_start_next: no byte delivered, required 3c");
    end else begin
      got = obs_q.pop_front();
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL false_start_next: dout=%h required %h", got, e);
      end
    end
  endtask

  task automatic test_frame_err();
    int fe0 = n_frame_err, v0 = n_valid_cyc;
    send_frame(8'h3C, 1'b0, par_of(8'h3C));
    drive_bit(1'b0);
    checks++;
    if (busy !== 1'b1 || baud_ena !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_break: busy,baud_ena=%b required 10", {busy, baud_ena});
    end
    rx = 1'b1;
    wait_clks(SYNC + 3);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_release: busy=%b required 0", busy);
    end
    checks++;
    if (n_frame_err - fe0 != 1) begin
      errors++;
      $display("FAIL frame_err_pulse: pulses=%0d required 1", n_frame_err - fe0);
    end
    checks++;
    if (obs_q.size() != 0 || n_valid_cyc != v0) begin
      errors++;
      $display("FAIL frame_err_nodata: bytes=%0d valid_cycles=%0d required 0 0",
               obs_q.size(), n_valid_cyc - v0);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [DATA_BITS-1:0] got, e;
    int ov0 = n_overrun;
    dout_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, par_of(8'h11));
    send_frame(8'h22, 1'b1, par_of(8'h22));
    wait_clks(4);
    wait_obs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL overrun_first: no byte delivered, required 11");
    end else begin
      got = obs_q.pop_front();
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL overrun_first: dout=%h required %h", got, e);
      end
    end
    checks++;
    if (dout !== 8'h11 || dout_valid !== 1'b1 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_hold: dout=%h valid=%b extra=%0d required 11 1 0",
               dout, dout_valid, obs_q.size());
    end
    checks++;
    if (n_overrun - ov0 != 1) begin
      errors++;
      $display("FAIL overrun_pulse: pulses=%0d required 1", n_overrun - ov0);
    end
    dout_ready = 1'b1;
    wait_clks(2);
    dout_ready = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drain: dout_valid=%b required 0", dout_valid);
    end
  endtask

  task automatic test_ready_at_delivery();
    bit ok;
    logic [DATA_BITS-1:0] got, e;
    int ov0 = n_overrun;
    int seen = 0;
    int budget = 0;
    dout_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, par_of(8'h11));
    fork
      send_frame(8'h22, 1'b1, par_of(8'h22));
      begin
        while (seen < NTICKS && budget < 400) begin
          @(negedge clk);
          budget++;
          if (baud_tick) seen++;
        end
        if (seen == NTICKS) begin
          #1 dout_ready = 1'b1;
        end
      end
    join
    wait_clks(4);
    checks++;
    if (seen != NTICKS) begin
      errors++;
      $display("FAIL ready_stop_tick: ticks=%0d required %0d", seen, NTICKS);
    end
    for (int k = 0; k < 2; k++) begin
      wait_obs(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL ready_bytes: byte %0d missing", k);
      end else begin
        got = obs_q.pop_front();
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL ready_bytes: dout=%h required %h", got, e);
        end
      end
    end
    checks++;
    if (n_overrun != ov0 || dout !== 8'h22) begin
      errors++;
      $display("FAIL ready_no_overrun: pulses=%0d dout=%h required 0 22", n_overrun - ov0, dout);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [DATA_BITS-1:0] got, e;
    logic [DATA_BITS+5:0] v;
    int fe0 = n_frame_err;
    dout_ready = 1'b0;
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1'b1, par_of(8'h66));
    wait_obs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_pre_byte: no byte delivered, required 66");
    end else begin
      got = obs_q.pop_front();
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL rst_pre_byte: dout=%h required %h", got, e);
      end
    end
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rstn = 1'b0;
    #1;
    v = {baud_ena, dout, dout_valid, frame_err, parity_err, overrun, busy};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL rst_mid_frame: outputs=%h required 0", v);
    end
    wait_clks(3);
    rstn = 1'b1;
    wait_clks(BAUDRATE);
    dout_ready = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, par_of(8'h5A));
    wait_obs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_next_byte: no byte delivered, required 5a");
    end else begin
      got = obs_q.pop_front();
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL rst_next_byte: dout=%h required %h", got, e);
      end
    end
    checks++;
    if (n_frame_err != fe0) begin
      errors++;
      $display("FAIL rst_no_frame_err: pulses=%0d required 0", n_frame_err - fe0);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    bit ok;
    logic [DATA_BITS-1:0] got, e;
    int pe0 = n_par_err, v0 = n_valid_cyc;
    dout_ready = 1'b1;
    send_frame(8'h01, 1'b1, 1'b0);
    wait_clks(4);
    checks++;
    if (n_par_err - pe0 != 1 || n_valid_cyc != v0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL parity_bad: pulses=%0d valid_cycles=%0d required 1 0",
               n_par_err - pe0, n_valid_cyc - v0);
    end
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1);
    wait_obs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL parity_good: no byte delivered, required 01");
    end else begin
      got = obs_q.pop_front();
      e = exp_q.pop_front();
      if (got !== e || n_par_err - pe0 != 1) begin
        errors++;
        $display("FAIL parity_good: dout=%h pulses=%0d required %h 1", got, n_par_err - pe0, e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_ready_at_delivery();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: expected left=%0d observed left=%0d required 0 0",
               exp_q.size(), obs_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
